// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one req/ack data-memory transaction per load/store, load lane extract/extend, MEM/WB register.
// Latency: non-memory ops 1 cycle; memory ops 1 IDLE cycle plus WAIT cycles until dmem_ack (2 cycles minimum).
// Backpressure: stall_o holds upstream while a memory op is outstanding; drops in the cycle the ack or timeout retires it.
//
// Ports: clk/rst (sync, active-low); EX/MEM fields (*_i); dmem_* data bus (registered req, ack pulse);
//        fwd_* MEM-stage forwarding for the hazard unit; valid_o/we_o/wa_o/wd_o MEM/WB register;
//        align_err_o / bus_err_o one-cycle error pulses.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        cregwa_i,
  input  logic [1:0]  cregwd_i,
  input  logic        regwe_i,
  input  logic [1:0]  memlen_i,
  input  logic        memwe_i,
  input  logic        load_sgn_i,
  input  logic [31:0] aluout_i,
  input  logic [31:0] rd2_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_o,
  output logic        fwd_we,
  output logic [4:0]  fwd_wa,
  output logic [31:0] fwd_wd,
  output logic        fwd_pend,
  output logic        valid_o,
  output logic        we_o,
  output logic [4:0]  wa_o,
  output logic [31:0] wd_o,
  output logic        align_err_o,
  output logic        bus_err_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Counter only needs to reach TIMEOUT-1; keep at least one bit so TIMEOUT of 0 or 1 still elaborates.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic TIMEOUT_EN = (TIMEOUT > 0);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          req_nxt, valid_nxt, we_nxt, aerr_nxt, berr_nxt;
  logic [4:0]    wa_nxt;
  logic [31:0]   wd_nxt;

  logic [4:0]  dest;
  logic        is_load, is_mem, misal, timeout_hit;
  logic [1:0]  a;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] load_val;

  assign a       = aluout_i[1:0];
  assign dest    = cregwa_i ? rd_i : rt_i;
  assign is_load = (cregwd_i == 2'b01);
  assign is_mem  = valid_i & (memwe_i | is_load);
  assign misal   = ((memlen_i == 2'b01) & a[0]) | (memlen_i[1] & (a != 2'b00));

  assign timeout_hit = TIMEOUT_EN & (state == S_WAIT) & ~dmem_ack & (cnt == CNT_LAST);

  // Upstream is released in the same cycle the transaction retires, so the next instruction loads at that edge.
  assign stall_o = is_mem & ~misal & ~((state == S_WAIT) & (dmem_ack | timeout_hit));

  assign fwd_we   = valid_i & regwe_i;
  assign fwd_wa   = dest;
  assign fwd_wd   = aluout_i;
  assign fwd_pend = valid_i & is_load;

  // Address/lane signals come straight from EX/MEM, which is frozen for the whole transaction.
  assign dmem_addr = {aluout_i[31:2], 2'b00};
  assign dmem_we   = dmem_req & memwe_i;

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = rd2_i;
    case (memlen_i)
      2'b00: begin
        dmem_be    = 4'b0001 << a;
        dmem_wdata = {4{rd2_i[7:0]}};
      end
      2'b01: begin
        dmem_be    = a[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{rd2_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_b = dmem_rdata[8*a +: 8];
  assign ld_h = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_val = dmem_rdata;
    case (memlen_i)
      2'b00:   load_val = {{24{load_sgn_i & ld_b[7]}}, ld_b};
      2'b01:   load_val = {{16{load_sgn_i & ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = dmem_req;
    valid_nxt = 1'b0;
    we_nxt    = 1'b0;
    wa_nxt    = wa_o;
    wd_nxt    = wd_o;
    aerr_nxt  = 1'b0;
    berr_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_i) begin
          if (!is_mem) begin
            valid_nxt = 1'b1;
            we_nxt    = regwe_i;
            wa_nxt    = dest;
            wd_nxt    = aluout_i;
          end else if (misal) begin
            // Retire the instruction without a bus cycle and without a register write.
            valid_nxt = 1'b1;
            wa_nxt    = dest;
            wd_nxt    = aluout_i;
            aerr_nxt  = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = '0;
            req_nxt   = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          valid_nxt = 1'b1;
          we_nxt    = regwe_i;
          wa_nxt    = dest;
          wd_nxt    = is_load ? load_val : aluout_i;
          req_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end else if (timeout_hit) begin
          valid_nxt = 1'b1;
          wa_nxt    = dest;
          wd_nxt    = aluout_i;
          berr_nxt  = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dmem_req    <= 1'b0;
      valid_o     <= 1'b0;
      we_o        <= 1'b0;
      wa_o        <= '0;
      wd_o        <= '0;
      align_err_o <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      dmem_req    <= req_nxt;
      valid_o     <= valid_nxt;
      we_o        <= we_nxt;
      wa_o        <= wa_nxt;
      wd_o        <= wd_nxt;
      align_err_o <= aerr_nxt;
      bus_err_o   <= berr_nxt;
    end
  end

endmodule
